// File: rtl/uart_rx_controller.sv
// UART receiver: 2-flop input synchronizer, start-bit validation, mid-bit sampling on a
// 16x-style oversample enable, LSB-first reassembly. Optional even parity via UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a tick that sees rx_s low
// START  | timing to mid start bit, re-checking to reject glitches
// DATA   | sampling DATA_BITS data bits at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, publishing the word or flagging a framing error
// BREAK  | line held low after a framing error, waiting for it to return high
module uart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_error_r;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            rx_meta  <= rx_in;
            rx_s     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            rx_data        <= '0;
            data_valid     <= 1'b0;
            framing_error  <= 1'b0;
            parity_error_r <= 1'b0;
            busy           <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit     <= 1'b0;
`endif
        end else begin
            data_valid     <= 1'b0;
            framing_error  <= 1'b0;
            parity_error_r <= 1'b0;
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            parity_bit <= rx_s;
                            state      <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                rx_data    <= shift_reg;
                                data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                // even parity: data plus parity bit must hold an even number of ones
                                parity_error_r <= (^shift_reg) ^ parity_bit;
`endif
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_r;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomized bench for uart_rx_controller: frames are generated at bit level and every
// received word is matched against a queue of expected words kept by the bench.
module tb_uart_rx_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];      // {parity_error, data}
    int         exp_fe     = 0;
    int         got_fe     = 0;
    int         exp_valid  = 0;
    int         got_valid  = 0;
    logic [7:0] last_good  = 8'h00;

    uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_in),
        .rx_data(rx_data), .data_valid(data_valid), .framing_error(framing_error),
        .parity_error(parity_error), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            got_valid++;
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
                chk("parity_error", {31'd0, parity_error}, {31'd0, e[8]});
                last_good = e[7:0];
            end
            chk("valid_fe_overlap", {31'd0, framing_error}, 32'd0);
        end
        if (framing_error) begin
            got_fe++;
            chk("fe_parity_precedence", {31'd0, parity_error}, 32'd0);
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k++;
        end
        @(negedge clk);
    endtask

    // Drives one frame; good stop bits register an expected word with the model.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        logic perr;
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = par_flip;
`endif
        if (stop) begin
            exp_q.push_back({perr, d});
            exp_valid++;
        end else begin
            exp_fe++;
        end
        rx_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^d) ^ par_flip;
        wait_ticks(16);
`endif
        rx_in = stop;
        wait_ticks(16);
    endtask

    initial begin
        rx_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_fe", {31'd0, framing_error}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, 1'b0);
        chk("busy_after_a5", {31'd0, busy}, 32'd0);
        chk("a5_count", got_valid, 1);
        wait_ticks(16);

        // short low glitch is rejected at the mid-start check
        rx_in = 1'b0;
        wait_ticks(4);
        rx_in = 1'b1;
        wait_ticks(6);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        wait_ticks(32);
        chk("glitch_no_valid", got_valid, exp_valid);

        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(320);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_single_fe", got_fe, 1);
        chk("break_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
        rx_in = 1'b1;
        wait_ticks(32);
        chk("break_exit_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_ticks(16);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(16);
        chk("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(16);
`endif

        // reset in the middle of data bit 4 discards the partial frame
        rx_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            wait_ticks(16);
        end
        rx_in = 1'b1;
        wait_ticks(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        wait_ticks(48);
        chk("mid_reset_no_valid", got_valid, exp_valid);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_ticks(16);

        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'($urandom_range(0, 1)));
            wait_ticks(16 * $urandom_range(0, 2));
        end
        wait_ticks(32);

        chk("total_valid", got_valid, exp_valid);
        chk("total_fe", got_fe, exp_fe);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_busy", {31'd0, busy}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
